// File: rtl/duty_cycle_ramp.sv
// duty_cycle_ramp: slew-limited PWM duty command stage with a one-entry command holding register
module duty_cycle_ramp #(
    parameter int DUTY_CYCLE_WIDTH = 9,
    parameter int COUNTER_WIDTH    = 10,
    parameter int MAX_COUNTER      = 1024,
    parameter int MAX_DUTY         = 480,
    parameter int SLEW_STEP        = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [DUTY_CYCLE_WIDTH-1:0] cmd_duty,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    output logic                        period_start,
    output logic                        at_target,
    output logic [1:0]                  state
);
    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [COUNTER_WIDTH-1:0]    LAST = COUNTER_WIDTH'(MAX_COUNTER - 1);
    localparam logic [DUTY_CYCLE_WIDTH-1:0] MAXD = DUTY_CYCLE_WIDTH'(MAX_DUTY);
    localparam logic [DUTY_CYCLE_WIDTH:0]   STEP = (DUTY_CYCLE_WIDTH + 1)'(SLEW_STEP);

    logic [COUNTER_WIDTH-1:0]    counter;
    logic [DUTY_CYCLE_WIDTH-1:0] target;
    logic [DUTY_CYCLE_WIDTH-1:0] pending;
    logic                        pending_full;
    logic                        boundary;
    logic                        accept;
    logic [DUTY_CYCLE_WIDTH-1:0] clamped;
    logic [DUTY_CYCLE_WIDTH-1:0] eff;
    logic [DUTY_CYCLE_WIDTH:0]   up;
    logic [DUTY_CYCLE_WIDTH:0]   dn;
    logic [DUTY_CYCLE_WIDTH-1:0] step_duty;
    logic [1:0]                  next_state;

    // Boundary detect, command handshake and one slew step computed in one extra bit so nothing wraps
    always_comb begin
        boundary     = (counter == LAST);
        cmd_ready    = enable && !pending_full;
        accept       = cmd_valid && cmd_ready;
        period_start = (counter == '0);
        at_target    = (state == S_HOLD) || (state == S_OFF);
        clamped      = (cmd_duty > MAXD) ? MAXD : cmd_duty;
        eff          = pending_full ? pending : target;
        up           = {1'b0, duty_cycle} + STEP;
        dn           = {1'b0, duty_cycle} - STEP;
        step_duty    = (eff > duty_cycle) ? ((up >= {1'b0, eff}) ? eff : up[DUTY_CYCLE_WIDTH-1:0])
                     : (({1'b0, duty_cycle} >= ({1'b0, eff} + STEP)) ? dn[DUTY_CYCLE_WIDTH-1:0] : eff);
        next_state   = (state == S_OFF && eff == '0) ? S_OFF : ((step_duty == eff) ? S_HOLD : S_RAMP);
    end

    // Free-running period counter, keeps running while disabled so the PWM phase stays aligned
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            counter <= '0;
        else
            counter <= boundary ? '0 : counter + 1'b1;
    end

    // Duty, target and FSM move only at the period boundary; disable clears everything on the next edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            duty_cycle   <= '0;
            target       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            state        <= S_OFF;
        end else if (!enable) begin
            duty_cycle   <= '0;
            target       <= '0;
            pending_full <= 1'b0;
            state        <= S_OFF;
        end else begin
            if (boundary) begin
                target     <= eff;
                duty_cycle <= step_duty;
                state      <= next_state;
            end
            if (accept)
                pending <= clamped;
            pending_full <= accept || (pending_full && !boundary);
        end
    end
endmodule

// File: tb/tb_duty_cycle_ramp.sv
// tb_duty_cycle_ramp: directed checks of ramp, clamp, boundary commands, disable and reset
module tb_duty_cycle_ramp;
    localparam int DW = 9;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] cmd_duty = '0;
    logic          cmd_ready;
    logic [DW-1:0] duty_cycle;
    logic          period_start;
    logic          at_target;
    logic [1:0]    state;
    int            checks = 0;
    int            errors = 0;

    duty_cycle_ramp #(
        .DUTY_CYCLE_WIDTH(DW),
        .COUNTER_WIDTH(4),
        .MAX_COUNTER(16),
        .MAX_DUTY(480),
        .SLEW_STEP(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .cmd_duty(cmd_duty),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .duty_cycle(duty_cycle),
        .period_start(period_start),
        .at_target(at_target),
        .state(state)
    );

    always #5 clock = ~clock;

    // Advance to the next negedge where the counter reads 0, bounded
    task automatic sync0();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!period_start && n < 40);
        if (!period_start) begin
            checks++;
            errors++;
            $display("FAIL sync0 period_start got 0 want 1 within 40 cycles");
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic goto(input int k);
        sync0();
        tick(k);
    endtask

    task automatic send(input logic [DW-1:0] v);
        cmd_duty  = v;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        tick(2);
        checks++; if (duty_cycle !== 0)    begin errors++; $display("FAIL reset_duty got %0d want 0", duty_cycle); end
        checks++; if (state !== 2'd0)      begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL reset_period_start got %0b want 1", period_start); end
        checks++; if (at_target !== 1'b1)  begin errors++; $display("FAIL reset_at_target got %0b want 1", at_target); end
        reset_n = 1'b1;
        tick(1);
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_counter_runs period_start got %0b want 0", period_start); end
    endtask

    task automatic test_ramp_up();
        logic [DW-1:0] exp;
        goto(3);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL up_ready got %0b want 1", cmd_ready); end
        send(9'd40);
        checks++; if (duty_cycle !== 0) begin errors++; $display("FAIL up_before_boundary got %0d want 0", duty_cycle); end
        for (int i = 1; i <= 5; i++) begin
            exp = DW'(8 * i);
            sync0();
            checks++; if (duty_cycle !== exp) begin errors++; $display("FAIL up_duty got %0d want %0d", duty_cycle, exp); end
            checks++; if (state !== (i == 5 ? 2'd2 : 2'd1)) begin errors++; $display("FAIL up_state step %0d got %0d", i, state); end
            if (i == 1) begin
                tick(8);
                checks++; if (duty_cycle !== 9'd8) begin errors++; $display("FAIL up_midperiod got %0d want 8", duty_cycle); end
            end
        end
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL up_at_target got %0b want 1", at_target); end
    endtask

    task automatic test_clamp();
        int exp;
        goto(3);
        send(9'd500);
        exp = 40;
        while (exp < 480) begin
            exp += 8;
            sync0();
            checks++; if (duty_cycle !== DW'(exp)) begin errors++; $display("FAIL clamp_duty got %0d want %0d", duty_cycle, exp); end
        end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL clamp_state got %0d want 2", state); end
        sync0();
        checks++; if (duty_cycle !== 9'd480) begin errors++; $display("FAIL clamp_hold got %0d want 480", duty_cycle); end
    endtask

    task automatic test_ramp_down();
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        checks++; if (duty_cycle !== 0) begin errors++; $display("FAIL down_clear got %0d want 0", duty_cycle); end
        goto(3);
        send(9'd20);
        sync0();
        checks++; if (duty_cycle !== 9'd8)  begin errors++; $display("FAIL down_pre1 got %0d want 8", duty_cycle); end
        sync0();
        checks++; if (duty_cycle !== 9'd16) begin errors++; $display("FAIL down_pre2 got %0d want 16", duty_cycle); end
        sync0();
        checks++; if (duty_cycle !== 9'd20) begin errors++; $display("FAIL down_pre3 got %0d want 20", duty_cycle); end
        checks++; if (state !== 2'd2)       begin errors++; $display("FAIL down_hold20 got %0d want 2", state); end
        goto(3);
        send(9'd3);
        sync0();
        checks++; if (duty_cycle !== 9'd12) begin errors++; $display("FAIL down_12 got %0d want 12", duty_cycle); end
        checks++; if (state !== 2'd1)       begin errors++; $display("FAIL down_ramp got %0d want 1", state); end
        sync0();
        checks++; if (duty_cycle !== 9'd4)  begin errors++; $display("FAIL down_4 got %0d want 4", duty_cycle); end
        sync0();
        checks++; if (duty_cycle !== 9'd3)  begin errors++; $display("FAIL down_3 got %0d want 3", duty_cycle); end
        checks++; if (state !== 2'd2)       begin errors++; $display("FAIL down_hold3 got %0d want 2", state); end
    endtask

    task automatic test_boundary_cmd();
        goto(15);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready got %0b want 1", cmd_ready); end
        send(9'd100);
        checks++; if (duty_cycle !== 9'd3) begin errors++; $display("FAIL bnd_unchanged got %0d want 3", duty_cycle); end
        checks++; if (cmd_ready !== 1'b0)  begin errors++; $display("FAIL bnd_full got %0b want 0", cmd_ready); end
        tick(5);
        checks++; if (cmd_ready !== 1'b0)  begin errors++; $display("FAIL bnd_second_ready got %0b want 0", cmd_ready); end
        send(9'd7);
        sync0();
        checks++; if (duty_cycle !== 9'd11) begin errors++; $display("FAIL bnd_step1 got %0d want 11", duty_cycle); end
        checks++; if (state !== 2'd1)       begin errors++; $display("FAIL bnd_state got %0d want 1", state); end
        sync0();
        checks++; if (duty_cycle !== 9'd19) begin errors++; $display("FAIL bnd_step2 got %0d want 19", duty_cycle); end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        sync0();
        checks++; if (duty_cycle !== 0) begin errors++; $display("FAIL en_rise_duty got %0d want 0", duty_cycle); end
        checks++; if (state !== 2'd0)   begin errors++; $display("FAIL en_rise_state got %0d want 0", state); end
        goto(3);
        send(9'd200);
        for (int i = 1; i <= 8; i++) sync0();
        checks++; if (duty_cycle !== 9'd64) begin errors++; $display("FAIL en_pre got %0d want 64", duty_cycle); end
        tick(7);
        enable = 1'b0;
        tick(1);
        checks++; if (duty_cycle !== 0)    begin errors++; $display("FAIL en_drop_duty got %0d want 0", duty_cycle); end
        checks++; if (state !== 2'd0)      begin errors++; $display("FAIL en_drop_state got %0d want 0", state); end
        checks++; if (cmd_ready !== 1'b0)  begin errors++; $display("FAIL en_drop_ready got %0b want 0", cmd_ready); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL en_drop_counter got %0b want 0", period_start); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_ramp();
        goto(3);
        send(9'd100);
        repeat (3) sync0();
        checks++; if (duty_cycle !== 9'd24) begin errors++; $display("FAIL rst_pre got %0d want 24", duty_cycle); end
        tick(5);
        #3 reset_n = 1'b0;
        #1;
        checks++; if (duty_cycle !== 0)      begin errors++; $display("FAIL rst_duty got %0d want 0", duty_cycle); end
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL rst_state got %0d want 0", state); end
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL rst_period_start got %0b want 1", period_start); end
        checks++; if (cmd_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready got %0b want 1", cmd_ready); end
        checks++; if (at_target !== 1'b1)    begin errors++; $display("FAIL rst_at_target got %0b want 1", at_target); end
        @(negedge clock);
        reset_n = 1'b1;
        tick(15);
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rst_cnt15 got %0b want 0", period_start); end
        tick(1);
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL rst_cnt_wrap got %0b want 1", period_start); end
        checks++; if (duty_cycle !== 0)      begin errors++; $display("FAIL rst_after1 got %0d want 0", duty_cycle); end
        sync0();
        checks++; if (duty_cycle !== 0)      begin errors++; $display("FAIL rst_after2 got %0d want 0", duty_cycle); end
        checks++; if (state !== 2'd0)        begin errors++; $display("FAIL rst_after_state got %0d want 0", state); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_clamp();
        test_ramp_down();
        test_boundary_cmd();
        test_enable_drop();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
